// File: rtl/glyph_render_ctrl.sv
// glyph_render_ctrl: 8x8 font ROM row sequencer and pixel serialiser (optional macro GLYPH_ROW_PREFETCH_EN removes inter-row bubbles)
module glyph_render_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int GLYPH_ROWS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Req,
    input  logic [7:0]            i_Code,
    output logic                  o_Ready,
    output logic [ADDR_WIDTH-1:0] o_Addr,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_Pixel,
    output logic                  o_PixValid,
    input  logic                  i_PixReady,
    output logic [2:0]            o_Col,
    output logic [2:0]            o_Row,
    output logic                  o_Done
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;
    localparam logic [2:0] LAST_ROW = 3'(GLYPH_ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(DATA_WIDTH - 1);
    state_t                state, state_n;
    logic [7:0]            code, code_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [2:0]            col_n, row_n;
    logic                  valid_n, done_n, hs;

    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [7:0] c, input logic [2:0] r);
        return ADDR_WIDTH'({1'b0, c, 1'b0, r});
    endfunction

    assign hs      = o_PixValid && i_PixReady;
    assign o_Pixel = shift[0];

    // next-state, address, counters and shift register update
    always_comb begin
        state_n = state;
        code_n  = code;
        shift_n = shift;
        addr_n  = o_Addr;
        col_n   = o_Col;
        row_n   = o_Row;
        valid_n = o_PixValid;
        done_n  = 1'b0;
        case (state)
            IDLE: if (i_Req) begin
                code_n  = i_Code;
                row_n   = '0;
                addr_n  = row_addr(i_Code, 3'd0);
                state_n = FETCH;
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                shift_n = i_Data;
                col_n   = '0;
                valid_n = 1'b1;
                state_n = SHIFT;
`ifdef GLYPH_ROW_PREFETCH_EN
                if (o_Row != LAST_ROW) addr_n = row_addr(code, o_Row + 3'd1);
`endif
            end
            SHIFT: if (hs) begin
                if (o_Col != LAST_COL) begin
                    shift_n = shift >> 1;
                    col_n   = o_Col + 3'd1;
                end else if (o_Row != LAST_ROW) begin
                    row_n = o_Row + 3'd1;
`ifdef GLYPH_ROW_PREFETCH_EN
                    shift_n = i_Data;
                    col_n   = '0;
                    if (row_n != LAST_ROW) addr_n = row_addr(code, row_n + 3'd1);
`else
                    addr_n  = row_addr(code, row_n);
                    valid_n = 1'b0;
                    state_n = FETCH;
`endif
                end else begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any glyph in flight
    always_ff @(posedge i_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            code       <= '0;
            shift      <= '0;
            o_Addr     <= '0;
            o_Col      <= '0;
            o_Row      <= '0;
            o_PixValid <= 1'b0;
            o_Done     <= 1'b0;
            o_Ready    <= 1'b1;
        end else begin
            state      <= state_n;
            code       <= code_n;
            shift      <= shift_n;
            o_Addr     <= addr_n;
            o_Col      <= col_n;
            o_Row      <= row_n;
            o_PixValid <= valid_n;
            o_Done     <= done_n;
            o_Ready    <= (state_n == IDLE);
        end
    end
endmodule
